i2c_ui_sequencer: RTL and testbench

Front-panel transaction sequencer for the I2C master. It takes the already-synchronized switch and button levels, debounces the button and latches a command from the switches on each press. It issues one I2C transaction to the byte-level I2C master core over a valid/ready handshake, then waits for the response and publishes the read data and error status to the LED/status logic. A watchdog aborts transactions the core never completes.

---
 rtl/i2c_ui_pkg.sv | 5 +
 rtl/i2c_ui_sequencer_btn_debounce.sv | 30 +++
 rtl/i2c_ui_sequencer.sv | 86 ++++++++
 tb/tb_i2c_ui_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_ui_pkg.sv
// i2c_ui_pkg: shared state and error encodings for the I2C front-panel sequencer
package i2c_ui_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_NACK = 2'b01, ERR_TIMEOUT = 2'b10} err_t;
endpackage

// File: rtl/i2c_ui_sequencer_btn_debounce.sv
// btn_debounce: accepts a level change after DB_CYCLES constant cycles, flags rising edges
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic press
);
  localparam int W = $clog2(DB_CYCLES);
  localparam logic [W-1:0] C_MAX = W'(DB_CYCLES - 1);
  logic [W-1:0] r_cnt;
  logic r_stable, r_stable_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
    end else begin
      r_stable_q <= r_stable;
      if (raw == r_stable) r_cnt <= '0;
      else if (r_cnt == C_MAX) begin
        r_stable <= raw;
        r_cnt    <= '0;
      end else r_cnt <= r_cnt + W'(1);
    end
  assign stable = r_stable;
  assign press  = r_stable & ~r_stable_q;
endmodule

// File: rtl/i2c_ui_sequencer.sv
// i2c_ui_sequencer: button-triggered single I2C transaction with watchdog and status
module i2c_ui_sequencer
  import i2c_ui_pkg::*;
#(
  parameter int         N_SW        = 4,
  parameter int         DB_CYCLES   = 1_000_000,
  parameter int         TIMEOUT_CYC = 2_000_000,
  parameter logic [6:0] DEV_ADDR    = 7'h48,
  parameter logic [7:0] WR_DATA     = 8'hA5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sync_sw,
  input  logic            sync_btn,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic            cmd_rw,
  output logic [6:0]      cmd_addr,
  output logic [7:0]      cmd_reg,
  output logic [7:0]      cmd_wdata,
  input  logic            rsp_valid,
  input  logic            rsp_nack,
  input  logic [7:0]      rsp_rdata,
  output logic            busy,
  output logic            done,
  output logic [1:0]      err,
  output logic [7:0]      result
);
  localparam int WW = $clog2(TIMEOUT_CYC);
  localparam logic [WW-1:0] T_MAX = WW'(TIMEOUT_CYC - 1);
  state_t r_state, w_next;
  err_t r_err;
  logic [WW-1:0] r_wd;
  logic [7:0] r_reg, r_result;
  logic r_rw, w_stable, w_press, w_go, w_timeout, w_active;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (sync_btn),
    .stable (w_stable),
    .press  (w_press)
  );
  assign w_go      = w_press & w_stable;
  assign w_active  = (r_state == ISSUE) || (r_state == WAIT);
  assign w_timeout = w_active && (r_wd == T_MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go ? ISSUE : IDLE;
      ISSUE:   w_next = w_timeout ? DONE : cmd_ready ? WAIT : ISSUE;
      WAIT:    w_next = (rsp_valid || w_timeout) ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rw     <= 1'b0;
      r_reg    <= '0;
      r_wd     <= '0;
      r_err    <= ERR_OK;
      r_result <= '0;
    end else begin
      if (r_state == IDLE && w_go) begin
        r_rw  <= sync_sw[0];
        r_reg <= 8'(sync_sw[N_SW-1:1]);
        r_wd  <= '0;
      end else if (w_active) r_wd <= r_wd + WW'(1);
      // a response in the watchdog's final cycle takes priority over the timeout
      if (r_state == WAIT && rsp_valid) begin
        r_err <= rsp_nack ? ERR_NACK : ERR_OK;
        if (r_rw && !rsp_nack) r_result <= rsp_rdata;
      end else if (w_timeout) r_err <= ERR_TIMEOUT;
    end
  assign cmd_valid = (r_state == ISSUE);
  assign cmd_rw    = r_rw;
  assign cmd_addr  = DEV_ADDR;
  assign cmd_reg   = r_reg;
  assign cmd_wdata = WR_DATA;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign err       = r_err;
  assign result    = r_result;
endmodule

// File: tb/tb_i2c_ui_sequencer.sv
// tb_i2c_ui_sequencer: directed checks of read, NACK, bounce, timeout, busy and reset behaviour
module tb_i2c_ui_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sync_sw = '0;
  logic       sync_btn = 1'b0;
  logic       cmd_valid, cmd_ready = 1'b0, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_reg, cmd_wdata;
  logic       rsp_valid = 1'b0, rsp_nack = 1'b0;
  logic [7:0] rsp_rdata = '0;
  logic       busy, done;
  logic [1:0] err;
  logic [7:0] result;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  i2c_ui_sequencer #(.N_SW(4), .DB_CYCLES(4), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_sw   (sync_sw),
    .sync_btn  (sync_btn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_reg   (cmd_reg),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_nack  (rsp_nack),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      cyc = i;
      if (cmd_valid) break;
    end
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      cyc = i;
      if (done) break;
    end
  endtask
  task automatic respond(input logic nack, input logic [7:0] d);
    rsp_valid = 1'b1;
    rsp_nack  = nack;
    rsp_rdata = d;
    tick();
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
  endtask
  initial begin
    int  c;
    logic seen, ok;
    tick(2);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_rw", cmd_rw, 0);
    chk("rst_reg", cmd_reg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    rst_n = 1'b1;
    tick(2);
    // read transaction
    cmd_ready = 1'b1;
    sync_sw = 4'b0111;
    sync_btn = 1'b1;
    wait_valid(c);
    chk("rd_latency", c, 5);
    chk("rd_rw", cmd_rw, 1);
    chk("rd_reg", cmd_reg, 8'h03);
    chk("rd_addr", cmd_addr, 7'h48);
    tick();
    sync_btn = 1'b0;
    chk("rd_wait_novalid", cmd_valid, 0);
    tick(4);
    respond(1'b0, 8'h3C);
    chk("rd_done", done, 1);
    chk("rd_err", err, 2'b00);
    chk("rd_result", result, 8'h3C);
    tick();
    chk("rd_done_pulse", done, 0);
    chk("rd_idle", busy, 0);
    tick(8);
    // write with NACK
    sync_sw = 4'b1010;
    sync_btn = 1'b1;
    wait_valid(c);
    sync_btn = 1'b0;
    chk("wr_latency", c, 5);
    chk("wr_rw", cmd_rw, 0);
    chk("wr_reg", cmd_reg, 8'h05);
    chk("wr_wdata", cmd_wdata, 8'hA5);
    tick();
    respond(1'b1, 8'hFF);
    chk("wr_done", done, 1);
    chk("wr_err", err, 2'b01);
    chk("wr_result", result, 8'h3C);
    tick(8);
    // bounce rejection
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sync_btn = ((i / 2) % 2) == 0;
      tick();
      seen |= cmd_valid | busy;
    end
    sync_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= cmd_valid | busy;
    end
    chk("bounce_novalid", seen, 0);
    // timeout
    sync_sw = 4'b0001;
    sync_btn = 1'b1;
    wait_valid(c);
    sync_btn = 1'b0;
    chk("to_latency", c, 5);
    wait_done(c);
    chk("to_cycles", c, 16);
    chk("to_err", err, 2'b10);
    chk("to_result", result, 8'h3C);
    tick(2);
    respond(1'b0, 8'h99);
    chk("late_done", done, 0);
    chk("late_busy", busy, 0);
    chk("late_err", err, 2'b10);
    chk("late_result", result, 8'h3C);
    tick(8);
    // backpressure then busy press
    cmd_ready = 1'b0;
    sync_sw = 4'b0101;
    sync_btn = 1'b1;
    wait_valid(c);
    sync_btn = 1'b0;
    chk("bp_latency", c, 5);
    sync_sw = 4'b1110;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      ok &= cmd_valid && cmd_rw && (cmd_reg == 8'h02);
    end
    chk("bp_hold", ok, 1);
    cmd_ready = 1'b1;
    tick();
    chk("bp_accepted", cmd_valid, 0);
    sync_btn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= cmd_valid;
    end
    sync_btn = 1'b0;
    chk("busy_press_novalid", seen, 0);
    chk("busy_still", busy, 1);
    respond(1'b0, 8'h5A);
    chk("bp_done", done, 1);
    chk("bp_result", result, 8'h5A);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= cmd_valid;
    end
    chk("busy_press_notqueued", seen, 0);
    // reset while waiting
    sync_sw = 4'b0011;
    sync_btn = 1'b1;
    wait_valid(c);
    sync_btn = 1'b0;
    tick(3);
    chk("rw_in_wait", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", cmd_valid, 0);
    chk("arst_reg", cmd_reg, 0);
    chk("arst_result", result, 0);
    chk("arst_err", err, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    sync_btn = 1'b1;
    wait_valid(c);
    sync_btn = 1'b0;
    chk("fresh_latency", c, 5);
    chk("fresh_rw", cmd_rw, 1);
    chk("fresh_reg", cmd_reg, 8'h01);
    tick();
    respond(1'b0, 8'h77);
    chk("fresh_done", done, 1);
    chk("fresh_err", err, 2'b00);
    chk("fresh_result", result, 8'h77);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
